// File: rtl/rescale_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rescale_arbiter_if
// Description : Request and result handshake bundle for rescale_arbiter.
//               slave  - design side (accepts requests, produces results)
//               master - environment side (issues requests, consumes results)
//   req_valid [NUM_REQ]     per-requester request valid
//   req_data  [32*NUM_REQ]  signed 32-bit accumulators, requester i at [32*i+:32]
//   req_ready [NUM_REQ]     one-hot-or-zero accept strobe
//   out_valid / out_data[8] / out_id / out_ready   result handshake
// Revision    : 1.0 - initial release
// ============================================================================
interface rescale_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int c_idw = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  out_valid;
  logic [7:0]            out_data;
  logic [c_idw-1:0]      out_id;
  logic                  out_ready;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );
endinterface
`default_nettype wire

// File: rtl/rescale_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rescale_arbiter
// Description : Round-robin arbiter in front of a shared two-stage
//               rescale (arithmetic right shift) + ReLU/saturate-to-127 path.
//               Each requester owns a 5-bit shift register (RST_SHIFT reset).
//   clk, rst_b         clock, asynchronous active-low reset
//   bus (slave)        request / result handshake (see rescale_arbiter_if)
//   cfg_we/idx/shift   shift-register write port (out-of-range idx ignored)
//   busy               any pipeline stage holds valid data
// Options     : define RESCALE_ROUND_EN for round-half-up before shifting;
//               otherwise results are truncated (floor).
// Revision    : 1.0 - initial release
// ============================================================================
module rescale_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RST_SHIFT = 11
) (
  input  logic                       clk,
  input  logic                       rst_b,
  rescale_arbiter_if.slave           bus,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_REQ)-1:0] cfg_idx,
  input  logic [4:0]                 cfg_shift,
  output logic                       busy
);
  localparam int c_idw = $clog2(NUM_REQ);

  // Registered state
  logic [c_idw-1:0] ptr_q, ptr_d;
  logic [4:0]       shift_q [NUM_REQ];
  logic [4:0]       shift_d [NUM_REQ];
  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_data_q, s1_data_d;
  logic [c_idw-1:0] s1_id_q, s1_id_d;
  logic [4:0]       s1_shift_q, s1_shift_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [c_idw-1:0] out_id_q, out_id_d;

  // Combinational
  logic               w_found;
  logic [c_idw-1:0]   w_grant_id;
  logic [c_idw-1:0]   w_idx;
  logic [31:0]        w_grant_data;
  logic               w_s2_free, w_s1_adv, w_s1_free, w_accept;
  logic [NUM_REQ-1:0] w_req_ready;
  logic signed [32:0] w_data_ext, w_sum, w_res;
  logic [7:0]         w_sat;
`ifdef RESCALE_ROUND_EN
  logic signed [32:0] w_round;
`endif

  assign w_s2_free = !out_valid_q || bus.out_ready;
  assign w_s1_adv  = s1_valid_q && w_s2_free;
  assign w_s1_free = !s1_valid_q || w_s1_adv;
  // Gating with rst_b keeps req_ready low for the whole reset window.
  assign w_accept  = rst_b && w_found && w_s1_free;

  // Round-robin search: walk downwards so the candidate closest to ptr wins.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = '0;
    w_idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = c_idw'((int'(ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx;
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    w_req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == c_idw'(i)) begin
        w_grant_data   = bus.req_data[32*i +: 32];
        w_req_ready[i] = w_accept;
      end
    end
  end

  // Rescale in 33 bits so the rounding increment cannot overflow.
  always_comb begin
    w_data_ext = {s1_data_q[31], s1_data_q};
`ifdef RESCALE_ROUND_EN
    w_round = (s1_shift_q == 5'd0) ? 33'sd0 : (33'sd1 <<< (s1_shift_q - 5'd1));
    w_sum   = w_data_ext + w_round;
`else
    w_sum   = w_data_ext;
`endif
    w_res = w_sum >>> s1_shift_q;
    if (w_res < 33'sd0) begin
      w_sat = 8'd0;
    end else if (w_res > 33'sd127) begin
      w_sat = 8'd127;
    end else begin
      w_sat = w_res[7:0];
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    shift_d     = shift_q;
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_id_d     = s1_id_q;
    s1_shift_d  = s1_shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    // Comparing against each legal index naturally ignores out-of-range idx.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cfg_we && (cfg_idx == c_idw'(i))) begin
        shift_d[i] = cfg_shift;
      end
    end

    if (w_s2_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = w_sat;
        out_id_d   = s1_id_q;
      end
    end

    if (w_accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = w_grant_data;
      s1_id_d    = w_grant_id;
      // shift_q, not shift_d: a same-cycle write only affects later requests.
      s1_shift_d = shift_q[w_grant_id];
      ptr_d      = (w_grant_id == c_idw'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end else if (w_s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        shift_q[i] <= 5'(RST_SHIFT);
      end
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_id_q     <= '0;
      s1_shift_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      shift_q     <= shift_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_id_q     <= s1_id_d;
      s1_shift_q  <= s1_shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign busy          = s1_valid_q || out_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_rescale_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rescale_arbiter
// Description : Directed self-checking bench for rescale_arbiter (NUM_REQ=4,
//               RST_SHIFT=11). Honors RESCALE_ROUND_EN for expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rescale_arbiter;
  logic       clk = 1'b0;
  logic       rst_b;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [4:0] cfg_shift;
  logic       busy;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  rescale_arbiter_if #(.NUM_REQ(4)) bus ();

  rescale_arbiter #(.NUM_REQ(4), .RST_SHIFT(11)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_shift (cfg_shift),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stream_data();
    for (int i = 0; i < 4; i++) begin
      bus.req_data[32*i +: 32] = 32'((10 + i) * 2048);
    end
  endtask

  // One isolated request; returns observations for the caller to check.
  task automatic run_single(input logic [1:0] idx, input logic [31:0] d,
                            input logic we, input logic [4:0] sh,
                            output logic [3:0] rdy, output logic ov_mid,
                            output logic ov, output logic [7:0] od,
                            output logic [1:0] oid);
    bus.req_valid            = '0;
    bus.req_valid[idx]       = 1'b1;
    bus.req_data[32*idx +: 32] = d;
    cfg_we    = we;
    cfg_idx   = idx;
    cfg_shift = sh;
    #1;
    rdy = bus.req_ready;
    step();
    bus.req_valid = '0;
    cfg_we        = 1'b0;
    #1;
    ov_mid = bus.out_valid;
    step();
    ov  = bus.out_valid;
    od  = bus.out_data;
    oid = bus.out_id;
    step();
  endtask

  task automatic test_reset();
    rst_b         = 1'b0;
    cfg_we        = 1'b0;
    cfg_idx       = '0;
    cfg_shift     = '0;
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1111;
    set_stream_data();
    step();
    step();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 8'd0) $display("FAIL rst_out_data got=%0d exp=0", bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.out_id !== 2'd0) $display("FAIL rst_out_id got=%0d exp=0", bus.out_id); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready); else pass_cnt++;
    rst_b = 1'b1;
  endtask

  // All four valid held from reset: grants 0,1,2,3,0 and out_id 0,1,2,3.
  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_rdy = 4'b0001 << (c % 4);
      total_cnt++; if (bus.req_ready !== exp_rdy) $display("FAIL rr_ready[%0d] got=%b exp=%b", c, bus.req_ready, exp_rdy); else pass_cnt++;
      if (c < 2) begin
        total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rr_out_valid[%0d] got=%b exp=0", c, bus.out_valid); else pass_cnt++;
      end else begin
        total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL rr_out_valid[%0d] got=%b exp=1", c, bus.out_valid); else pass_cnt++;
        total_cnt++; if (bus.out_id !== 2'(c - 2)) $display("FAIL rr_out_id[%0d] got=%0d exp=%0d", c, bus.out_id, c - 2); else pass_cnt++;
        total_cnt++; if (bus.out_data !== 8'(8 + c)) $display("FAIL rr_out_data[%0d] got=%0d exp=%0d", c, bus.out_data, 8 + c); else pass_cnt++;
      end
      @(posedge clk);
    end
    #1;
    bus.req_valid = '0;
    step();
    step();
    step();
  endtask

  task automatic test_saturate();
    logic [3:0] rdy; logic ovm, ov; logic [7:0] od; logic [1:0] oid;
    run_single(2'd0, 32'h0003_F800, 1'b0, 5'd0, rdy, ovm, ov, od, oid);
    total_cnt++; if (rdy !== 4'b0001) $display("FAIL sat_ready got=%b exp=0001", rdy); else pass_cnt++;
    total_cnt++; if (ovm !== 1'b0) $display("FAIL sat_latency_early got=%b exp=0", ovm); else pass_cnt++;
    total_cnt++; if (ov !== 1'b1) $display("FAIL sat_out_valid got=%b exp=1", ov); else pass_cnt++;
    total_cnt++; if (od !== 8'd127) $display("FAIL sat_out_data got=%0d exp=127", od); else pass_cnt++;
    total_cnt++; if (oid !== 2'd0) $display("FAIL sat_out_id got=%0d exp=0", oid); else pass_cnt++;
  endtask

  task automatic test_clamp();
    logic [3:0] rdy; logic ovm, ov; logic [7:0] od; logic [1:0] oid;
    logic [7:0] exp_2047;
`ifdef RESCALE_ROUND_EN
    exp_2047 = 8'd1;
`else
    exp_2047 = 8'd0;
`endif
    run_single(2'd1, 32'hFFFF_F000, 1'b0, 5'd0, rdy, ovm, ov, od, oid);
    total_cnt++; if (od !== 8'd0) $display("FAIL neg_out_data got=%0d exp=0", od); else pass_cnt++;
    total_cnt++; if (oid !== 2'd1) $display("FAIL neg_out_id got=%0d exp=1", oid); else pass_cnt++;
    run_single(2'd2, 32'd2047, 1'b0, 5'd0, rdy, ovm, ov, od, oid);
    total_cnt++; if (od !== exp_2047) $display("FAIL small_out_data got=%0d exp=%0d", od, exp_2047); else pass_cnt++;
    total_cnt++; if (ov !== 1'b1) $display("FAIL small_out_valid got=%b exp=1", ov); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    set_stream_data();
    bus.req_valid = 4'b1111;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0001) $display("FAIL bp_ready0 got=%b exp=0001", bus.req_ready); else pass_cnt++;
    step();
    total_cnt++; if (bus.req_ready !== 4'b0010) $display("FAIL bp_ready1 got=%b exp=0010", bus.req_ready); else pass_cnt++;
    step();
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL bp_stall_ready[%0d] got=%b exp=0000", s, bus.req_ready); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== 8'd10)
        $display("FAIL bp_stall_hold[%0d] got=%b/%0d/%0d exp=1/0/10", s, bus.out_valid, bus.out_id, bus.out_data); else pass_cnt++;
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0100) $display("FAIL bp_release_ready got=%b exp=0100", bus.req_ready); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_id !== 2'd1 || bus.out_data !== 8'd11) $display("FAIL bp_out1 got=%0d/%0d exp=1/11", bus.out_id, bus.out_data); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b1000) $display("FAIL bp_ready3 got=%b exp=1000", bus.req_ready); else pass_cnt++;
    step();
    bus.req_valid = '0;
    total_cnt++; if (bus.out_id !== 2'd2 || bus.out_data !== 8'd12) $display("FAIL bp_out2 got=%0d/%0d exp=2/12", bus.out_id, bus.out_data); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd3 || bus.out_data !== 8'd13)
      $display("FAIL bp_out3 got=%b/%0d/%0d exp=1/3/13", bus.out_valid, bus.out_id, bus.out_data); else pass_cnt++;
    step();
    total_cnt++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_drained got=%b/%b exp=0/0", bus.out_valid, busy); else pass_cnt++;
  endtask

  task automatic test_cfg_shift();
    logic [3:0] rdy; logic ovm, ov; logic [7:0] od; logic [1:0] oid;
    run_single(2'd2, 32'd256, 1'b1, 5'd4, rdy, ovm, ov, od, oid);
    total_cnt++; if (rdy !== 4'b0100) $display("FAIL cfg_same_ready got=%b exp=0100", rdy); else pass_cnt++;
    total_cnt++; if (od !== 8'd0) $display("FAIL cfg_same_cycle_old_shift got=%0d exp=0", od); else pass_cnt++;
    run_single(2'd2, 32'd256, 1'b0, 5'd0, rdy, ovm, ov, od, oid);
    total_cnt++; if (od !== 8'd16) $display("FAIL cfg_new_shift got=%0d exp=16", od); else pass_cnt++;
    total_cnt++; if (oid !== 2'd2) $display("FAIL cfg_new_shift_id got=%0d exp=2", oid); else pass_cnt++;
    // Shift 0 (no rounding term) with a value above the clamp.
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_shift = 5'd0;
    step();
    cfg_we = 1'b0;
    run_single(2'd1, 32'd100, 1'b0, 5'd0, rdy, ovm, ov, od, oid);
    total_cnt++; if (od !== 8'd100) $display("FAIL shift0_pass got=%0d exp=100", od); else pass_cnt++;
    run_single(2'd1, 32'd200, 1'b0, 5'd0, rdy, ovm, ov, od, oid);
    total_cnt++; if (od !== 8'd127) $display("FAIL shift0_clamp got=%0d exp=127", od); else pass_cnt++;
  endtask

  // ptr is 2 here (last accept was requester 1).
  task automatic test_reset_mid();
    bus.req_data[32*1 +: 32] = 32'(20 * 2048);
    bus.req_data[32*3 +: 32] = 32'(30 * 2048);
    bus.req_valid = 4'b1010;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b1000) $display("FAIL mid_ready_a got=%b exp=1000", bus.req_ready); else pass_cnt++;
    step();
    total_cnt++; if (bus.req_ready !== 4'b0010) $display("FAIL mid_ready_b got=%b exp=0010", bus.req_ready); else pass_cnt++;
    step();
    bus.out_ready = 1'b0;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0000 || busy !== 1'b1 || bus.out_id !== 2'd3)
      $display("FAIL mid_full got=%b/%b/%0d exp=0000/1/3", bus.req_ready, busy, bus.out_id); else pass_cnt++;
    rst_b = 1'b0;
    #1;
    total_cnt++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_rst_clear got=%b/%b exp=0/0", bus.out_valid, busy); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 4'b0000 || bus.out_id !== 2'd0 || bus.out_data !== 8'd0)
      $display("FAIL mid_rst_outs got=%b/%0d/%0d exp=0000/0/0", bus.req_ready, bus.out_id, bus.out_data); else pass_cnt++;
    step();
    rst_b = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    total_cnt++; if (bus.req_ready !== 4'b0010) $display("FAIL mid_first_grant got=%b exp=0010", bus.req_ready); else pass_cnt++;
    step();
    bus.req_valid = '0;
    step();
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.out_data !== 8'd20)
      $display("FAIL mid_after_rst got=%b/%0d/%0d exp=1/1/20", bus.out_valid, bus.out_id, bus.out_data); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_saturate();
    test_clamp();
    test_backpressure();
    test_cfg_shift();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rescale_arbiter.md
RESCALE_ARBITER -- requirements
Module: rescale_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of accumulator requesters sharing one rescale/ReLU datapath (2..8).
REQ-002 SHALL have parameter RST_SHIFT, default 11, reset value of every per-requester shift register (0..31).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port req_data  input  32*NUM_REQ  signed 32-bit accumulators; requester i in bits [32*i+31:32*i].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot-or-zero accept strobe; combinational.
REQ-008 SHALL have port cfg_we  input  1  shift-register write enable.
REQ-009 SHALL have port cfg_idx  input  $clog2(NUM_REQ)  shift register index to write.
REQ-010 SHALL have port cfg_shift  input  5  new shift amount.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_data  output  8  signed result, range 0..127.
REQ-013 SHALL have port out_id  output  $clog2(NUM_REQ)  index of requester that produced out_data.
REQ-014 SHALL have port out_ready  input  1  downstream accept.
REQ-015 SHALL have port busy  output  1  high when any pipeline stage holds valid data.

Function
REQ-016 SHALL arbitrate round-robin: grant the first i with req_valid[i]=1 searching from pointer ptr upward, wrapping modulo NUM_REQ.
REQ-017 SHALL assert req_ready[i] only for the granted i, and only when stage S1 is empty or S1 advances this cycle.
REQ-018 SHALL, on accept (req_valid[i] & req_ready[i]), set ptr to (i+1) mod NUM_REQ; ptr unchanged when no accept.
REQ-019 SHALL capture data, id and the shift register of id into S1 on accept.
REQ-020 SHALL compute res = S1 data arithmetically right-shifted by the captured shift; result = 0 if res<0, 127 if res>127, else res[7:0]; register into output stage S2.
REQ-021 SHALL give latency 2: accept at edge k -> out_valid high after edge k+1, given out_ready high; throughput 1 result per cycle.
REQ-022 SHALL hold out_valid, out_data, out_id stable while out_valid=1 and out_ready=0; S1 advances into S2 only when S2 empty or out_ready=1.
REQ-023 SHALL, when S2 stalls and S1 full, deassert all req_ready.
REQ-024 SHALL write cfg_shift into shift register cfg_idx on cfg_we; new value applies to requests accepted on later cycles only.
REQ-025 SHALL, on cfg_we and accept of the same index in one cycle, use the old shift value for that request.
REQ-026 SHALL ignore cfg_idx >= NUM_REQ.
REQ-027 SHALL never drop or duplicate an accepted request.

Reset
REQ-028 SHALL, on rst_b low (also mid-operation), clear S1/S2 valid flags, discard in-flight data, set out_valid=0, out_data=0, out_id=0, busy=0, req_ready=0, ptr=0, every shift register = RST_SHIFT.
REQ-029 SHALL resume arbitration on the first rising edge after rst_b deasserts.

Configuration
REQ-030 SHALL, with macro RESCALE_ROUND_EN defined, add 2^(shift-1) to the data in 33-bit signed arithmetic before shifting when shift>0 (round-half-up).
REQ-031 SHALL, without RESCALE_ROUND_EN, truncate (floor) with no rounding adder.

Verification
REQ-032 SHALL cover: shift=11, data 0x0003_F800 on req 0 -> out_data 127, out_id 0, out_valid two cycles after accept.
REQ-033 SHALL cover: shift=11, data -4096 -> out_data 0; data 2047 -> 0 (truncate) or 1 (RESCALE_ROUND_EN, 2047+1024>>11=1).
REQ-034 SHALL cover: all four req_valid held high from reset -> grants 0,1,2,3,0 on consecutive cycles, out_id sequence 0,1,2,3.
REQ-035 SHALL cover: out_ready low 5 cycles with stream active -> out_data/out_id frozen, req_ready all 0 after S1 fills, no loss on release.
REQ-036 SHALL cover: cfg_we idx 2 shift 4 same cycle as accept of req 2 data 256 -> result uses shift 11 (0); next req 2 data 256 -> 16.
REQ-037 SHALL cover: rst_b pulsed low with S1 and S2 full -> out_valid 0, busy 0 immediately; first grant after reset goes to lowest valid index.
